// File: rtl/posit_div_seq.sv
// posit_div_seq
// -------------
// Multi-cycle mantissa quotient sequencer for the posit divider. It
// performs a radix-2 restoring division and produces one quotient bit per
// clock. The result is Quot = floor(Mantissa1 * 2^(2N) / Mantissa2) and
// Sticky = (remainder != 0).
//
// Handshake: an operand set transfers on a rising edge where in_valid and
// in_ready are both 1. A result transfers on a rising edge where out_valid
// and out_ready are both 1. in_ready and out_valid are registers that
// depend only on the FSM state, so there is no combinational path from
// in_valid or out_ready. Result outputs stay stable while out_valid=1 and
// out_ready=0.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake
//   Sign1, Sign2          operand signs
//   Mantissa1, Mantissa2  dividend / divisor mantissas (hidden 1 at bit N-1)
//   inf1, inf2, zero1, zero2  operand special flags
//   out_valid / out_ready result handshake
//   Quot [2N:0], Sticky   quotient and remainder-non-zero flag
//   Norm                  Quot[2N]; 0 means the consumer must shift left by one
//   Sign, inf, zero       result sign and special flags
//
// Optional build macro POSIT_DIV_EARLY_TERM_EN: when it is defined, the
// sequencer stops as soon as the partial remainder reaches zero. Quot and
// Sticky are identical with and without the macro; only the latency changes.

module posit_div_seq #(
    parameter int N  = 32,
    parameter int CW = $clog2(2*N+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           Sign1,
    input  logic           Sign2,
    input  logic [N-1:0]   Mantissa1,
    input  logic [N-1:0]   Mantissa2,
    input  logic           inf1,
    input  logic           inf2,
    input  logic           zero1,
    input  logic           zero2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N:0]   Quot,
    output logic           Sticky,
    output logic           Norm,
    output logic           Sign,
    output logic           inf,
    output logic           zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q;
    logic [N:0]     r_q;        // partial remainder; R < 2D keeps it in N+1 bits
    logic [N-1:0]   d_q;        // divisor
    logic [2*N:0]   quot_q;
    logic [CW-1:0]  cnt_q;      // index of the quotient bit produced this cycle
    logic           sticky_q;
    logic           sign_q;
    logic           inf_q;
    logic           zero_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic           q_bit_d;
    logic [N:0]     diff_d;     // R - q*D, unsigned, N+1 bits
    logic           special_d;
    logic           div_zero_d;
    logic           early_stop_d;

    always_comb begin
        q_bit_d    = (r_q >= {1'b0, d_q});
        diff_d     = r_q - (q_bit_d ? {1'b0, d_q} : {(N+1){1'b0}});
        div_zero_d = (Mantissa2 == '0);
        special_d  = inf1 | inf2 | zero1 | zero2 | div_zero_d;
    end

`ifdef POSIT_DIV_EARLY_TERM_EN
    // A zero remainder means every remaining quotient bit is 0, and those
    // bits were already cleared at capture.
    assign early_stop_d = (diff_d == '0);
`else
    assign early_stop_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            d_q         <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        d_q        <= Mantissa2;
                        r_q        <= {1'b0, Mantissa1};
                        sign_q     <= Sign1 ^ Sign2;
                        zero_q     <= zero1 | zero2;
                        // A zero divisor without a zero operand reads as infinity.
                        inf_q      <= inf1 | inf2 | (div_zero_d & ~(zero1 | zero2));
                        quot_q     <= '0;
                        sticky_q   <= 1'b0;
                        cnt_q      <= CW'(2*N);
                        in_ready_q <= 1'b0;
                        if (special_d) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    quot_q[cnt_q] <= q_bit_d;
                    r_q           <= {diff_d[N-1:0], 1'b0};
                    if (cnt_q == '0 || early_stop_d) begin
                        sticky_q    <= |diff_d;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // The IDLE state gives one bubble before the next capture.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Quot      = quot_q;
    assign Sticky    = sticky_q;
    assign Norm      = quot_q[2*N];
    assign Sign      = sign_q;
    assign inf       = inf_q;
    assign zero      = zero_q;

endmodule

// File: doc/posit_div_seq.md
# posit_div_seq

Multi-cycle sequencer for the posit divider's mantissa quotient. It replaces the single-cycle combinational `/` in the divide arithmetic stage with a radix-2 restoring iteration, one quotient bit per clock. It accepts decoded operand mantissas and flags over a valid/ready handshake. It returns a (2N+1)-bit quotient, sticky bit, sign and special-case flags to the normalise/round stage.

## Interface
Parameters:
- N, 32, posit width; mantissas are N bits with hidden 1 at bit N-1.
- CW, $clog2(2*N+1), width of the iteration counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  sequencer can accept an operand set.
- Sign1, Sign2  input  1 each  operand signs.
- Mantissa1  input  N  dividend mantissa, normalised (bit N-1 = 1 unless zero/inf).
- Mantissa2  input  N  divisor mantissa, normalised.
- inf1, inf2, zero1, zero2  input  1 each  operand special flags.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- Quot  output  2N+1  floor((Mantissa1·2^(2N)) / Mantissa2).
- Sticky  output  1  remainder non-zero.
- Norm  output  1  equals Quot[2N]; 0 means the consumer shifts left by 1 and decrements the exponent.
- Sign  output  1  Sign1 ^ Sign2.
- inf, zero  output  1 each  inf1|inf2, zero1|zero2.

## Operation
- State machine states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture D=Mantissa2 and R=Mantissa1 (R is N+1 bits). Register Sign, inf, zero. Clear Quot. Set cnt=2N.
  - If inf1|inf2|zero1|zero2 or Mantissa2==0: go to DONE with Quot=0, Sticky=0. Also set inf=1 when Mantissa2==0 and no zero flag.
  - Otherwise go to CALC.
- CALC, each cycle:
  - q = (R >= D).
  - Quot[cnt] = q.
  - R = (R - q·D) << 1.
  - If cnt==0: Sticky = |(R - q·D) and go to DONE. Otherwise cnt = cnt-1.
- Width rules:
  - R < 2D always holds, so R fits in N+1 bits.
  - The subtraction is unsigned, N+1 bits.
  - Quot[2N] is 0 or 1 because Mantissa1 < 2·Mantissa2.
- DONE:
  - out_valid=1. All result outputs are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- in_ready is 0 in CALC and DONE. A new operand is never accepted in the cycle the result is taken, so there is one bubble per operation.
- in_valid asserted outside IDLE is ignored. Input ports are sampled only at capture.
- Reset, asynchronous, any state including mid-CALC: state=IDLE, in_ready=1. out_valid, Quot, Sticky, Norm, Sign, inf, zero, cnt and R all go to 0. Any partial result is discarded.

## Timing
- Capture edge: IDLE→CALC.
- Normal latency: 2N+1 CALC cycles, then out_valid in the next cycle. That gives out_valid 2N+2 cycles after the capture edge (66 for N=32, 18 for N=8).
- Special/zero-divisor path: out_valid 1 cycle after the capture edge.
- Throughput: one result per 2N+3 cycles when out_ready is held high.
- out_valid and in_ready are registered and decoded from state only, with no combinational path from in_valid or out_ready.

## Configuration
- Macro: POSIT_DIV_EARLY_TERM_EN.
- Defined:
  - In CALC, if (R - q·D)==0 after a step, go directly to DONE with Sticky=0. All remaining Quot bits are already 0.
  - Latency becomes data-dependent, minimum 2 cycles from capture to out_valid.
- Undefined: always the full 2N+1 iterations; latency is fixed.
- The Quot and Sticky values are identical in both builds.

## Test plan
- N=8, Mantissa1=0x80, Mantissa2=0x80 -> Quot=0x10000, Sticky=0, Norm=1. out_valid at cycle 18 (macro off) or cycle 2 (macro on).
- N=8, 0xC0 / 0x80 -> Quot=0x18000, Sticky=0, Norm=1. Then 0x80 / 0xC0 -> Quot=0x0AAAA, Sticky=1, Norm=0, 18 cycles in both builds.
- zero2=1 with any mantissas -> out_valid after 1 cycle, Quot=0, zero=1, Sign=Sign1^Sign2. Mantissa2=0 with no flags -> inf=1.
- Back-pressure: out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0. in_valid pulses during CALC/DONE are ignored. Raising out_ready gives IDLE next cycle.
- Assert rst mid-CALC (cnt=5) -> all outputs 0 immediately (asynchronous). After release, a fresh 0x80/0x80 completes correctly.
- Random sweep: 1000 normalised N=8 pairs checked against floor(M1·2^16/M2) and the remainder≠0 sticky. Cover both builds.
